data_memory_responder: RTL and testbench

Responder end of the MEM-stage data-memory interface. The pipeline's MEM stage initiates a load or store request. This block accepts it with a valid/ready handshake, holds it for a configurable access latency, commits or reads the word, and returns a one-cycle response. While a request is outstanding it drives a stall so the hazard logic can freeze the upstream pipeline registers.

---
 rtl/data_memory_responder_pkg.sv | 20 ++
 rtl/data_memory_responder_if.sv | 27 ++
 rtl/data_memory_responder_ram.sv | 28 ++
 rtl/data_memory_responder.sv | 124 ++++++++++++
 tb/tb_data_memory_responder.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// latency counter width and the legal LATENCY range.
package data_memory_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int CNT_W       = 4;
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;

  // Counter value loaded at accept so the edge where it reads zero is the commit edge.
  function automatic logic [CNT_W-1:0] latency_preload(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// MEM-stage data-memory bus: request handshake, one-cycle response and stall.
interface data_memory_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_zero;
  logic              rsp_err;
  logic              stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_zero, rsp_err, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_zero, rsp_err, stall
  );
endinterface

// File: rtl/data_memory_responder_ram.sv
// Word storage for the responder: synchronous write, registered read, no reset
// so the contents survive a pipeline reset.
module data_memory_responder_ram #(
  parameter int DEPTH_LOG2 = 8,
  parameter int DATA_W     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_rdata
);
  logic [DATA_W-1:0] r_mem [0:(2**DEPTH_LOG2)-1];
  logic [DATA_W-1:0] r_rdata;

  // Array write and read-data register, both only on enabled edges.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: accepts one MEM-stage request at a time, waits LATENCY
// edges, performs the access and returns a one-cycle response while driving stall.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  data_memory_responder_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_INIT = latency_preload(LATENCY);

  if ((LATENCY < LATENCY_MIN) || (LATENCY > LATENCY_MAX)) begin : g_latency_check
    $error("data_memory_responder: LATENCY %0d outside %0d..%0d",
           LATENCY, LATENCY_MIN, LATENCY_MAX);
  end

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rsp_valid;
  logic              r_rsp_write;
  logic              r_rsp_err;
  logic              r_rsp_load;

  logic              w_oor;
  logic              w_commit;
  logic              w_ram_we;
  logic              w_ram_re;
  logic              w_ready;
  logic              w_stall;
  logic [DATA_W-1:0] w_ram_rdata;
  logic [DATA_W-1:0] w_rdata;

  // Any address bit at or above DEPTH_LOG2 makes the access out of range.
  assign w_oor = (r_addr >> DEPTH_LOG2) != '0;

  // Handshake, stall, array enables and response-data gating from registered state.
  always_comb begin
    w_ready  = (r_state != ST_BUSY);
    w_commit = (r_state == ST_BUSY) && (r_cnt == '0);
    w_ram_we = w_commit && r_write && !w_oor;
    w_ram_re = w_commit && !r_write && !w_oor;
    w_stall  = (r_state == ST_BUSY) || (w_ready && bus.req_valid);
    if (r_rsp_load) begin
      w_rdata = w_ram_rdata;
    end else begin
      w_rdata = '0;
    end
  end

  // Request FSM: accept, count down the latency, commit, then present the response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_load  <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_load  <= 1'b0;
      case (r_state)
        ST_IDLE, ST_RESP: begin
          if (bus.req_valid) begin
            r_write <= bus.req_write;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_cnt   <= CNT_INIT;
            r_state <= ST_BUSY;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_write <= r_write;
            r_rsp_err   <= w_oor;
            r_rsp_load  <= !r_write && !w_oor;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  data_memory_responder_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (r_addr[DEPTH_LOG2-1:0]),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign bus.req_ready = w_ready;
  assign bus.stall     = w_stall;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_write = r_rsp_write;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = w_rdata;
  assign bus.rsp_zero  = r_rsp_valid && !r_rsp_write && (w_rdata == '0);
endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized scoreboard bench for data_memory_responder against an array-based
// reference model of the memory and the request/response timing.
module tb_data_memory_responder;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int DEPTH_LOG2 = 8;
  localparam int LAT        = 2;
  localparam int NWORDS     = 1 << DEPTH_LOG2;

  typedef struct {
    int          t;
    logic        w;
    logic [15:0] rdata;
    logic        zero;
    logic        err;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  int          checks   = 0;
  int          errors   = 0;
  int          edge_cnt = 0;
  int          last_t0  = -100;
  bit          in_reset = 1'b0;
  logic [15:0] model [NWORDS];
  exp_t        exp_q [$];

  data_memory_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  data_memory_responder #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .LATENCY    (LAT)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request takes effect in order at acceptance; its response
  // appears LAT edges after the accepting edge.
  task automatic push(input logic w, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    bit   oor;
    oor     = (int'(a) >= NWORDS);
    e.t     = edge_cnt + 1 + LAT;
    e.w     = w;
    e.err   = oor;
    e.rdata = 16'h0000;
    if (w) begin
      if (!oor) model[a[7:0]] = d;
    end else if (!oor) begin
      e.rdata = model[a[7:0]];
    end
    e.zero  = !w && (e.rdata == 16'h0000);
    exp_q.push_back(e);
    last_t0 = edge_cnt + 1;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
    int guard;
    guard = 0;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && guard < 50) begin
      bus.req_write = 1'($urandom_range(0, 1));
      bus.req_addr  = 16'($urandom);
      bus.req_wdata = 16'($urandom);
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
    end else begin
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      push(w, a, d);
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: checks handshake/stall every cycle and pops the scoreboard on responses.
  initial begin
    forever begin
      bit   busy;
      exp_t e;
      @(negedge clk);
      #1;
      if (in_reset) begin
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_stall", 32'(bus.stall), 32'd0);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
      end else begin
        busy = (last_t0 <= edge_cnt) && (edge_cnt < last_t0 + LAT);
        chk("req_ready", 32'(bus.req_ready), 32'(!busy));
        chk("stall", 32'(bus.stall), 32'(busy || bus.req_valid));
        if (bus.rsp_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_time", 32'(edge_cnt), 32'(e.t));
            chk("rsp_write", 32'(bus.rsp_write), 32'(e.w));
            chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
            chk("rsp_zero", 32'(bus.rsp_zero), 32'(e.zero));
            chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          end
        end else begin
          chk("rsp_idle_fields",
              32'({bus.rsp_write, bus.rsp_rdata, bus.rsp_zero, bus.rsp_err}), 32'd0);
        end
      end
    end
  end

  initial begin
    logic [15:0] d;
    logic [15:0] a;
    logic [15:0] old;
    int          g;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0000;
    bus.req_wdata = 16'h0000;

    // Reset asserted between edges: outputs must clear at once.
    #3;
    rst_n    = 1'b0;
    in_reset = 1'b1;
    #1;
    chk("async_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("async_rst_stall", 32'(bus.stall), 32'd0);
    chk("async_rst_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (3) @(negedge clk);
    #2;
    rst_n    = 1'b1;
    in_reset = 1'b0;
    @(negedge clk);

    // Preload every word back-to-back so the model knows the whole array.
    for (int i = 0; i < NWORDS; i++) begin
      if (i == 16)      d = 16'h0000;
      else if (i == 17) d = 16'h0001;
      else if (i == 3)  d = 16'h1111;
      else              d = 16'($urandom);
      issue(1'b1, 16'(i), d);
    end
    idle(2);

    issue(1'b1, 16'h0005, 16'hBEEF);
    idle(2);
    issue(1'b0, 16'h0005, 16'h0000);
    idle(1);
    issue(1'b0, 16'h0010, 16'h0000);
    issue(1'b0, 16'h0011, 16'h0000);
    idle(3);
    issue(1'b1, 16'h0007, 16'h1234);
    issue(1'b0, 16'h0007, 16'h0000);
    idle(2);
    issue(1'b1, 16'h0100, 16'h5555);
    issue(1'b0, 16'h0000, 16'h0000);
    issue(1'b0, 16'h0100, 16'h0000);
    idle(2);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) a = 16'($urandom) | 16'h0100;
      else                           a = 16'($urandom_range(0, NWORDS - 1));
      if ($urandom_range(0, 3) == 0) d = 16'h0000;
      else                           d = 16'($urandom);
      issue(1'($urandom_range(0, 1)), a, d);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    // Reset during BUSY discards an uncommitted store.
    idle(3);
    issue(1'b1, 16'h0003, 16'h1111);
    idle(3);
    old = model[3];
    issue(1'b1, 16'h0003, 16'hAAAA);
    bus.req_valid = 1'b0;
    #2;
    rst_n    = 1'b0;
    in_reset = 1'b1;
    #1;
    chk("midop_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midop_rst_stall", 32'(bus.stall), 32'd0);
    chk("midop_rst_req_ready", 32'(bus.req_ready), 32'd1);
    model[3] = old;
    exp_q.delete();
    last_t0 = -100;
    repeat (2) @(negedge clk);
    #2;
    rst_n    = 1'b1;
    in_reset = 1'b0;
    @(negedge clk);
    issue(1'b0, 16'h0003, 16'h0000);
    idle(1);

    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
